// File: rtl/fpga_wdi_monitor.sv
// rtl/fpga_wdi_monitor.sv - receive-side watchdog-kick supervisor
// Flags EARLY / TIMEOUT / STARTUP faults on an asynchronous kick line, timed by a 100us strobe.
module fpga_wdi_monitor #(
  parameter int MIN_TICKS     = 5,
  parameter int MAX_TICKS     = 15,
  parameter int STARTUP_TICKS = 100,
  parameter int CNT_W         = 8
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        PULSE_100US,
  input  logic        WDI_IN,
  input  logic        WD_EN,
  input  logic        CLR_FAULT,
  output logic        WD_OK,
  output logic        WD_FAULT,
  output logic [1:0]  FAULT_CODE,
  output logic [15:0] KICK_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_EARLY   = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;
  localparam logic [1:0] CODE_STARTUP = 2'b11;

  localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_C        = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] MAX_LAST     = CNT_W'(MAX_TICKS - 1);
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_kick_cnt;
  logic [1:0]       r_code;
  logic             r_ok;
  logic             r_fault;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [15:0]      w_next_kick_cnt;
  logic [1:0]       w_next_code;
  logic             w_kick_edge;

  assign w_kick_edge = r_sync2 & ~r_hist;
  assign w_cnt_inc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  // Thresholds use the pre-update count, and a kick always wins over a same-cycle tick.
  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    w_next_kick_cnt = r_kick_cnt;
    w_next_code     = r_code;
    if (!WD_EN) begin
      w_next_state    = S_IDLE;
      w_next_cnt      = '0;
      w_next_kick_cnt = '0;
      w_next_code     = CODE_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next_state = S_ARM;
          w_next_cnt   = '0;
        end
        S_ARM: begin
          if (w_kick_edge) begin
            w_next_state    = S_RUN;
            w_next_cnt      = '0;
            w_next_kick_cnt = r_kick_cnt + 16'd1;
          end else if (PULSE_100US) begin
            if (r_cnt == STARTUP_LAST) begin
              w_next_state = S_FAULT;
              w_next_cnt   = '0;
              w_next_code  = CODE_STARTUP;
            end else begin
              w_next_cnt = w_cnt_inc;
            end
          end
        end
        S_RUN: begin
          if (w_kick_edge) begin
            w_next_cnt = '0;
            if (r_cnt < MIN_C) begin
              w_next_state = S_FAULT;
              w_next_code  = CODE_EARLY;
            end else begin
              w_next_kick_cnt = r_kick_cnt + 16'd1;
            end
          end else if (PULSE_100US) begin
            if (r_cnt == MAX_LAST) begin
              w_next_state = S_FAULT;
              w_next_cnt   = '0;
              w_next_code  = CODE_TIMEOUT;
            end else begin
              w_next_cnt = w_cnt_inc;
            end
          end
        end
        S_FAULT: begin
          w_next_cnt = '0;
          if (CLR_FAULT) begin
            w_next_state = S_ARM;
            w_next_code  = CODE_NONE;
          end
        end
        default: begin
          w_next_state    = S_IDLE;
          w_next_cnt      = '0;
          w_next_kick_cnt = '0;
          w_next_code     = CODE_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_hist     <= 1'b0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_kick_cnt <= '0;
      r_code     <= CODE_NONE;
      r_ok       <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_sync1    <= WDI_IN;
      r_sync2    <= r_sync1;
      r_hist     <= r_sync2;
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_kick_cnt <= w_next_kick_cnt;
      r_code     <= w_next_code;
      r_ok       <= (w_next_state == S_RUN);
      r_fault    <= (w_next_state == S_FAULT);
    end
  end

  assign WD_OK      = r_ok;
  assign WD_FAULT   = r_fault;
  assign FAULT_CODE = r_code;
  assign KICK_CNT   = r_kick_cnt;

endmodule

// File: tb/tb_fpga_wdi_monitor.sv
// tb/tb_fpga_wdi_monitor.sv - scoreboard bench for fpga_wdi_monitor
// Stimulus pushes predicted outputs per clock; a negedge monitor pops and compares.
module tb_fpga_wdi_monitor;

  localparam int MIN_T = 5;
  localparam int MAX_T = 15;
  localparam int STARTUP_T = 100;

  localparam int M_IDLE = 0;
  localparam int M_ARM = 1;
  localparam int M_RUN = 2;
  localparam int M_FAULT = 3;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b1;
  logic        PULSE_100US = 1'b0;
  logic        WDI_IN = 1'b0;
  logic        WD_EN = 1'b0;
  logic        CLR_FAULT = 1'b0;
  logic        WD_OK;
  logic        WD_FAULT;
  logic [1:0]  FAULT_CODE;
  logic [15:0] KICK_CNT;

  fpga_wdi_monitor #(
    .MIN_TICKS(MIN_T), .MAX_TICKS(MAX_T), .STARTUP_TICKS(STARTUP_T), .CNT_W(8)
  ) dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .PULSE_100US(PULSE_100US), .WDI_IN(WDI_IN),
    .WD_EN(WD_EN), .CLR_FAULT(CLR_FAULT), .WD_OK(WD_OK), .WD_FAULT(WD_FAULT),
    .FAULT_CODE(FAULT_CODE), .KICK_CNT(KICK_CNT)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  typedef struct {
    int       cyc;
    logic     ok;
    logic     fault;
    logic [1:0] code;
    logic [15:0] kicks;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Reference model: plain integers, WDI history as a delay line of levels.
  int m_mode = M_IDLE;
  int m_ticks = 0;
  int m_kicks = 0;
  int m_code = 0;
  logic w1 = 0, w2 = 0, w3 = 0;
  int wdi_left = 0;
  logic clr_pend = 0;
  logic rst_pend = 0;

  always @(posedge OPB_CLK) cyc++;

  always @(negedge OPB_CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (WD_OK !== e.ok || WD_FAULT !== e.fault || FAULT_CODE !== e.code || KICK_CNT !== e.kicks) begin
        errors++;
        $display("FAIL outputs cyc=%0d got ok=%b fault=%b code=%b kicks=%0d want ok=%b fault=%b code=%b kicks=%0d",
                 cyc, WD_OK, WD_FAULT, FAULT_CODE, KICK_CNT, e.ok, e.fault, e.code, e.kicks);
      end
    end
  end

  task automatic model_edge();
    logic kick;
    if (OPB_RST) begin
      m_mode = M_IDLE; m_ticks = 0; m_kicks = 0; m_code = 0;
      w1 = 0; w2 = 0; w3 = 0;
      return;
    end
    kick = w2 & ~w3;
    w3 = w2; w2 = w1; w1 = WDI_IN;
    if (!WD_EN) begin
      m_mode = M_IDLE; m_ticks = 0; m_kicks = 0; m_code = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_ARM; m_ticks = 0;
    end else if (m_mode == M_ARM) begin
      if (kick) begin
        m_mode = M_RUN; m_ticks = 0; m_kicks = (m_kicks + 1) % 65536;
      end else if (PULSE_100US) begin
        m_ticks++;
        if (m_ticks == STARTUP_T) begin m_mode = M_FAULT; m_code = 3; end
      end
    end else if (m_mode == M_RUN) begin
      if (kick) begin
        if (m_ticks < MIN_T) begin m_mode = M_FAULT; m_code = 1; end
        else m_kicks = (m_kicks + 1) % 65536;
        m_ticks = 0;
      end else if (PULSE_100US) begin
        m_ticks++;
        if (m_ticks == MAX_T) begin m_mode = M_FAULT; m_code = 2; end
      end
    end else begin
      if (CLR_FAULT) begin m_mode = M_ARM; m_code = 0; m_ticks = 0; end
    end
  endtask

  task automatic step(input logic tk);
    exp_t e;
    WDI_IN = (wdi_left > 0);
    if (wdi_left > 0) wdi_left--;
    PULSE_100US = tk;
    CLR_FAULT = clr_pend;
    OPB_RST = rst_pend;
    clr_pend = 0;
    rst_pend = 0;
    model_edge();
    e.cyc = cyc + 1;
    e.ok = (m_mode == M_RUN);
    e.fault = (m_mode == M_FAULT);
    e.code = 2'(m_code);
    e.kicks = 16'(m_kicks);
    sb.push_back(e);
    @(posedge OPB_CLK); #1;
  endtask

  // One tick period of 4 clocks, strobe on the last; kick_at<0 means no kick.
  // A kick rising at phase 1 produces its edge in the strobe cycle.
  task automatic period(input int kick_at);
    for (int c = 0; c < 4; c++) begin
      if (c == kick_at) wdi_left = 2;
      step(c == 3);
    end
  endtask

  task automatic periods(input int n);
    for (int i = 0; i < n; i++) period(-1);
  endtask

  initial begin
    @(posedge OPB_CLK); #1;
    rst_pend = 1; step(0);
    rst_pend = 1; step(0);
    step(0); step(0);

    // Regular 1ms kicks
    WD_EN = 1; step(0); step(0);
    for (int k = 0; k < 50; k++) begin
      period(int'($urandom_range(0, 1)));
      periods(9);
    end
    // Kicks stop -> TIMEOUT, then clear
    periods(MAX_T + 2);
    clr_pend = 1; step(0); step(0);
    // Early and exactly-minimum intervals
    period(0); periods(2); period(0);
    clr_pend = 1; step(0);
    period(0); periods(MIN_T - 1); period(0);
    periods(3); period(0); periods(MIN_T - 1); period(0);
    periods(MAX_T + 1);
    // STARTUP fault, later kicks ignored
    WD_EN = 0; step(0); WD_EN = 1; step(0);
    periods(STARTUP_T + 2);
    period(0); periods(6); period(1); periods(2);
    // Kick coincident with the timeout tick, then real timeout
    clr_pend = 1; step(0);
    period(1); periods(MAX_T - 1); period(1);
    periods(MAX_T + 1);
    // Reset in RUN with 7 kicks, reset in FAULT, disable mid-RUN
    WD_EN = 0; step(0); WD_EN = 1; step(0);
    for (int k = 0; k < 7; k++) begin period(0); periods(6); end
    rst_pend = 1; step(0); step(0); step(0);
    period(0); periods(2); period(0); periods(2);
    rst_pend = 1; step(0); step(0); step(0);
    period(0); periods(6); period(0); periods(3);
    WD_EN = 0; step(0); step(0); WD_EN = 1; step(0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        WD_EN = 0; step(0); WD_EN = 1;
      end else if (r < 8) begin
        clr_pend = 1;
      end else if (r < 9) begin
        rst_pend = 1; step(0);
      end
      periods(int'($urandom_range(0, 16)));
      period(int'($urandom_range(0, 1)));
    end

    @(negedge OPB_CLK); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
